// File: rtl/wb_pkg.sv
// Shared constants and entry type for the register-file writeback path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  localparam logic [3:0] REG_PC    = 4'd15;
  localparam int         NUM_REGS  = 16;
  localparam int         WB_ADDR_W = 4;
  localparam int         WB_DATA_W = 32;

  // One queued result: destination register and the value to write there.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-write, single-read circular buffer with occupancy count; exposes storage and valid mask.
// Latency: an entry written at edge N is visible at the head after edge N when the buffer was empty.
// Backpressure: none internally; callers gate writes on count so the buffer never overflows.
import wb_pkg::*;

module wb_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t,
  parameter int  PTR_W   = $clog2(DEPTH),
  parameter int  CNT_W   = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr0_vld,
  input  entry_t           wr0_dat,
  input  logic             wr1_vld,
  input  entry_t           wr1_dat,
  input  logic             rd_vld,
  output entry_t           head_dat,
  output logic [PTR_W-1:0] head_ptr,
  output logic [CNT_W-1:0] count,
  output entry_t           entries [DEPTH],
  output logic [DEPTH-1:0] entry_vld
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage: slot wr1 is only used together with wr0, so it always lands one past wr0.
  always_ff @(posedge clk) begin
    if (wr0_vld) mem[wr_ptr] <= wr0_dat;
    if (wr1_vld) mem[wr_ptr + PTR_W'(1)] <= wr1_dat;
  end

  // Pointers and count; reset beats clear, clear beats any traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr0_vld) + PTR_W'(wr1_vld);
      rd_ptr <= rd_ptr + PTR_W'(rd_vld);
      count  <= count + CNT_W'(wr0_vld) + CNT_W'(wr1_vld) - CNT_W'(rd_vld);
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off       = '0;
    entry_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PTR_W'(i) - rd_ptr;
      entry_vld[i] = CNT_W'(off) < count;
    end
  end

  assign entries  = mem;
  assign head_dat = mem[rd_ptr];
  assign head_ptr = rd_ptr;

endmodule

// File: rtl/writeback_queue.sv
// Ordered writeback queue: merges load and ALU results, redirects R15 to the PC, exports a pending scoreboard.
// Latency: result accepted at edge N is written at edge N+1 when the queue was empty and not held.
// Backpressure: memReady/aluReady from registered count only (room for 1 / 2); wbHold stalls draining.
// Optional build macro WB_FORWARD_EN adds the combinational youngest-entry forwarding ports.
import wb_pkg::*;

module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memDest,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluDest,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluReady,
  input  logic              wbHold,
  input  logic              flush,
  output logic [ADDR_W-1:0] writeDestination,
  output logic              writeEnable,
  output logic [DATA_W-1:0] writeData,
  output logic              pcWriteValid,
  output logic [DATA_W-1:0] pcWriteData,
  output logic [15:0]       pending,
`ifdef WB_FORWARD_EN
  input  logic [ADDR_W-1:0] fwdReg1,
  input  logic [ADDR_W-1:0] fwdReg2,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic [DATA_W-1:0] fwdData1,
  output logic [DATA_W-1:0] fwdData2,
`endif
  output logic [CNT_W-1:0]  queueCount
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem_entry;
  entry_t           alu_entry;
  entry_t           wr0_dat;
  entry_t           head_dat;
  entry_t           entries [DEPTH];
  logic [DEPTH-1:0] entry_vld;
  logic [PTR_W-1:0] head_ptr;
  logic [CNT_W-1:0] count;
  logic             mem_acc;
  logic             alu_acc;
  logic             deq;
  logic             head_is_pc;

  assign mem_entry = '{dest: memDest, data: memData};
  assign alu_entry = '{dest: aluDest, data: aluData};

  // Room is judged on the registered count alone; a same-cycle drain earns no credit.
  assign memReady = !flush && (count < CNT_W'(DEPTH));
  assign aluReady = !flush && (count < CNT_W'(DEPTH-1));
  assign mem_acc  = memValid && memReady;
  assign alu_acc  = aluValid && aluReady;

  // Load result goes in first; ALU result takes the second slot only when both are accepted.
  assign wr0_dat = mem_acc ? mem_entry : alu_entry;

  assign deq        = (count != '0) && !wbHold;
  assign head_is_pc = head_dat.dest == ADDR_W'(REG_PC);

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .wr0_vld   (mem_acc || alu_acc),
    .wr0_dat   (wr0_dat),
    .wr1_vld   (mem_acc && alu_acc),
    .wr1_dat   (alu_entry),
    .rd_vld    (deq),
    .head_dat  (head_dat),
    .head_ptr  (head_ptr),
    .count     (count),
    .entries   (entries),
    .entry_vld (entry_vld)
  );

  assign queueCount = count;

  // Head issue: R15 goes to the PC port, everything else to the register file; all zero when idle.
  always_comb begin
    writeEnable      = 1'b0;
    writeDestination = '0;
    writeData        = '0;
    pcWriteValid     = 1'b0;
    pcWriteData      = '0;
    if (deq) begin
      if (head_is_pc) begin
        pcWriteValid = 1'b1;
        pcWriteData  = head_dat.data;
      end else begin
        writeEnable      = 1'b1;
        writeDestination = head_dat.dest;
        writeData        = head_dat.data;
      end
    end
  end

  // Scoreboard: one bit per register with any live entry aimed at it.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (32'(entries[i].dest) < NUM_REGS))
        pending[entries[i].dest[3:0]] = 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  // Forwarding: walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwdHit1  = 1'b0;
    fwdHit2  = 1'b0;
    fwdData1 = '0;
    fwdData2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PTR_W'(k);
      if (entry_vld[idx] && entries[idx].dest == fwdReg1) begin
        fwdHit1  = 1'b1;
        fwdData1 = entries[idx].data;
      end
      if (entry_vld[idx] && entries[idx].dest == fwdReg2) begin
        fwdHit2  = 1'b1;
        fwdData2 = entries[idx].data;
      end
    end
  end
`else
  logic unused_head_ptr;
  assign unused_head_ptr = ^head_ptr;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with hand-computed expectations.
// Latency: inputs change 1 ns after posedge; outputs checked after settling, away from the edge.
// Backpressure: exercised through wbHold, full queue and flush.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        memValid, aluValid, wbHold, flush;
  logic [3:0]  memDest, aluDest;
  logic [31:0] memData, aluData;
  logic        memReady, aluReady;
  logic [3:0]  writeDestination;
  logic        writeEnable;
  logic [31:0] writeData;
  logic        pcWriteValid;
  logic [31:0] pcWriteData;
  logic [15:0] pending;
  logic [2:0]  queueCount;
`ifdef WB_FORWARD_EN
  logic [3:0]  fwdReg1, fwdReg2;
  logic        fwdHit1, fwdHit2;
  logic [31:0] fwdData1, fwdData2;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .memValid         (memValid),
    .memDest          (memDest),
    .memData          (memData),
    .memReady         (memReady),
    .aluValid         (aluValid),
    .aluDest          (aluDest),
    .aluData          (aluData),
    .aluReady         (aluReady),
    .wbHold           (wbHold),
    .flush            (flush),
    .writeDestination (writeDestination),
    .writeEnable      (writeEnable),
    .writeData        (writeData),
    .pcWriteValid     (pcWriteValid),
    .pcWriteData      (pcWriteData),
    .pending          (pending),
`ifdef WB_FORWARD_EN
    .fwdReg1          (fwdReg1),
    .fwdReg2          (fwdReg2),
    .fwdHit1          (fwdHit1),
    .fwdHit2          (fwdHit2),
    .fwdData1         (fwdData1),
    .fwdData2         (fwdData2),
`endif
    .queueCount       (queueCount)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge, then let inputs/outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memValid = 1'b0; memDest = '0; memData = '0;
    aluValid = 1'b0; aluDest = '0; aluData = '0;
  endtask

  task automatic check_write(input string tag, input logic [3:0] d, input logic [31:0] v);
    check({tag, "_we"},   writeEnable, 1);
    check({tag, "_dest"}, writeDestination, d);
    check({tag, "_data"}, writeData, v);
  endtask

  initial begin
    reset = 1'b1; wbHold = 1'b0; flush = 1'b0;
    idle_inputs();
`ifdef WB_FORWARD_EN
    fwdReg1 = '0; fwdReg2 = '0;
`endif
    #1;
    step(); step();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_count",   queueCount, 0);
    check("rst_pending", pending, 0);
    check("rst_we",      writeEnable, 0);
    check("rst_pcv",     pcWriteValid, 0);
    check("rst_memrdy",  memReady, 1);
    check("rst_alurdy",  aluReady, 1);

    // 1: single ALU result, one-cycle latency
    aluValid = 1'b1; aluDest = 4'd3; aluData = 32'hAAAAAAAA;
    step();
    idle_inputs();
    check_write("t1", 4'd3, 32'hAAAAAAAA);
    check("t1_pending", pending, 16'h0008);
    check("t1_count",   queueCount, 1);
    step();
    check("t1_pending_clr", pending, 0);
    check("t1_count_clr",   queueCount, 0);
    check("t1_we_clr",      writeEnable, 0);

    // 2: simultaneous mem + alu, mem drains first
    memValid = 1'b1; memDest = 4'd1; memData = 32'h11;
    aluValid = 1'b1; aluDest = 4'd2; aluData = 32'h22;
    step();
    idle_inputs();
    check("t2_count2", queueCount, 2);
    check_write("t2_first", 4'd1, 32'h11);
    step();
    check("t2_count1", queueCount, 1);
    check_write("t2_second", 4'd2, 32'h22);
    step();
    check("t2_count0", queueCount, 0);
    check("t2_we0",    writeEnable, 0);

    // 3: fill under hold, then drain in order
    wbHold = 1'b1;
    memValid = 1'b1; memDest = 4'd4; memData = 32'h44;
    aluValid = 1'b1; aluDest = 4'd5; aluData = 32'h55;
    step();
    check("t3_count2",   queueCount, 2);
    check("t3_hold_we",  writeEnable, 0);
    check("t3_alurdy2",  aluReady, 1);
    memDest = 4'd6; memData = 32'h66;
    aluDest = 4'd7; aluData = 32'h77;
    step();
    idle_inputs();
    check("t3_count4",   queueCount, 4);
    check("t3_memrdy",   memReady, 0);
    check("t3_alurdy",   aluReady, 0);
    check("t3_we_held",  writeEnable, 0);
    check("t3_pending",  pending, 16'h00F0);
    wbHold = 1'b0;
    #1;
    check_write("t3_w0", 4'd4, 32'h44);
    step();
    check("t3_count3", queueCount, 3);
    check_write("t3_w1", 4'd5, 32'h55);
    step();
    check_write("t3_w2", 4'd6, 32'h66);
    step();
    check_write("t3_w3", 4'd7, 32'h77);
    step();
    check("t3_count0", queueCount, 0);

    // 4: R15 redirect to PC
    aluValid = 1'b1; aluDest = 4'd15; aluData = 32'h100;
    step();
    idle_inputs();
    check("t4_pcv",     pcWriteValid, 1);
    check("t4_pcdata",  pcWriteData, 32'h100);
    check("t4_we",      writeEnable, 0);
    check("t4_pending", pending, 16'h8000);
    step();
    check("t4_pcv_clr",     pcWriteValid, 0);
    check("t4_pending_clr", pending, 0);

    // 5: flush at count 3 with an ALU offer
    wbHold = 1'b1;
    memValid = 1'b1; memDest = 4'd1; memData = 32'hA1;
    aluValid = 1'b1; aluDest = 4'd2; aluData = 32'hA2;
    step();
    aluValid = 1'b0;
    memDest = 4'd3; memData = 32'hA3;
    step();
    memValid = 1'b0;
    #1;
    check("t5_count3", queueCount, 3);
    check("t5_memrdy3", memReady, 1);
    check("t5_alurdy3", aluReady, 0);
    flush = 1'b1;
    aluValid = 1'b1; aluDest = 4'd9; aluData = 32'h99;
    #1;
    check("t5_flush_alurdy", aluReady, 0);
    check("t5_flush_memrdy", memReady, 0);
    step();
    flush = 1'b0;
    idle_inputs();
    check("t5_flush_count",   queueCount, 0);
    check("t5_flush_pending", pending, 0);
    check("t5_flush_we",      writeEnable, 0);

    // 5b: reset mid-fill, with an offer present during reset
    memValid = 1'b1; memDest = 4'd8; memData = 32'h88;
    aluValid = 1'b1; aluDest = 4'd9; aluData = 32'h99;
    step();
    check("t5_fill_count", queueCount, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    wbHold = 1'b0;
    #1;
    check("t5_rst_count",   queueCount, 0);
    check("t5_rst_pending", pending, 0);
    check("t5_rst_we",      writeEnable, 0);

`ifdef WB_FORWARD_EN
    // 6: forwarding picks the youngest R5
    wbHold = 1'b1;
    aluValid = 1'b1; aluDest = 4'd5; aluData = 32'h1;
    step();
    aluData = 32'h2;
    step();
    idle_inputs();
    fwdReg1 = 4'd5; fwdReg2 = 4'd6;
    #1;
    check("t6_hit1",  fwdHit1, 1);
    check("t6_data1", fwdData1, 32'h2);
    check("t6_hit2",  fwdHit2, 0);
    check("t6_data2", fwdData2, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wbHold = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
